// File: rtl/clock_timekeeper_pkg.sv
// Shared types, constants and time-step helpers for the 12-hour timekeeper.
package clock_pkg;
   localparam int HOUR_WIDTH = 4;
   localparam int MIN_WIDTH  = 6;

   localparam logic [MIN_WIDTH-1:0]  MAX_SEC  = 6'd59;
   localparam logic [MIN_WIDTH-1:0]  MAX_MIN  = 6'd59;
   localparam logic [HOUR_WIDTH-1:0] MAX_HOUR = 4'd12;
   localparam logic [HOUR_WIDTH-1:0] MIN_HOUR = 4'd1;

   // FSM encoding kept as plain constants so older tools can share it
   typedef logic [1:0] state_t;
   localparam state_t ST_STOPPED = 2'd0;
   localparam state_t ST_RUN     = 2'd1;
   localparam state_t ST_SET     = 2'd2;

   typedef struct packed {
      logic                  pm;
      logic [HOUR_WIDTH-1:0] hour;
   } hour_pm_t;

   // 12 -> 1 keeps the meridiem; 11 -> 12 is where AM/PM flips
   function automatic hour_pm_t next_hour(input logic [HOUR_WIDTH-1:0] hour,
                                          input logic                  pm);
      hour_pm_t r;
      r.pm   = pm;
      r.hour = hour + 4'd1;
      if (hour == MAX_HOUR)
         r.hour = MIN_HOUR;
      else if (hour == (MAX_HOUR - 4'd1))
         r.pm = ~pm;
      return r;
   endfunction

   function automatic logic [MIN_WIDTH-1:0] next_min(input logic [MIN_WIDTH-1:0] min);
      return (min == MAX_MIN) ? '0 : min + 6'd1;
   endfunction
endpackage

// File: rtl/clock_timekeeper_if.sv
// Control/time bus of the timekeeper. With TIMEKEEPER_CHIME_EN defined the
// bus also carries the top-of-hour chime pulse.
interface clock_timekeeper_if;
   import clock_pkg::*;

   logic                  run_en_pi;
   logic                  set_mode_pi;
   logic                  increment_minute_pi;
   logic                  increment_hour_pi;
   logic [MIN_WIDTH-1:0]  seconds_po;
   logic [MIN_WIDTH-1:0]  minutes_po;
   logic [HOUR_WIDTH-1:0] hours_po;
   logic                  pm_po;
   logic                  sec_pulse_po;
`ifdef TIMEKEEPER_CHIME_EN
   logic                  chime_po;

   modport master (output run_en_pi, set_mode_pi, increment_minute_pi, increment_hour_pi,
                   input  seconds_po, minutes_po, hours_po, pm_po, sec_pulse_po, chime_po);
   modport slave  (input  run_en_pi, set_mode_pi, increment_minute_pi, increment_hour_pi,
                   output seconds_po, minutes_po, hours_po, pm_po, sec_pulse_po, chime_po);
`else
   modport master (output run_en_pi, set_mode_pi, increment_minute_pi, increment_hour_pi,
                   input  seconds_po, minutes_po, hours_po, pm_po, sec_pulse_po);
   modport slave  (input  run_en_pi, set_mode_pi, increment_minute_pi, increment_hour_pi,
                   output seconds_po, minutes_po, hours_po, pm_po, sec_pulse_po);
`endif
endinterface

// File: rtl/clock_timekeeper_tick_prescaler.sv
// Divides clk by TICKS_PER_SEC; o_tick is high in the last cycle of each
// second so the consumer updates on that same edge.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic clk,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);
   localparam int               CW   = $clog2(TICKS_PER_SEC);
   localparam logic [CW-1:0]    LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick = i_en && (r_cnt == LAST);

   // count while enabled, hold otherwise; clear wins over everything
   always_ff @(posedge clk) begin
      if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= o_tick ? '0 : r_cnt + CW'(1);
   end
endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour time-of-day keeper with run/stop/set modes.
// Optional: define TIMEKEEPER_CHIME_EN to add chime_po on the bus.
module clock_timekeeper
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100,
   parameter int RESET_HOUR    = 12,
   parameter int RESET_MIN     = 0
) (
   input  logic               clk_pi,
   input  logic               rst_n_pi,
   clock_timekeeper_if.slave  bus
);
   localparam logic [HOUR_WIDTH-1:0] R_HOUR = HOUR_WIDTH'(RESET_HOUR);
   localparam logic [MIN_WIDTH-1:0]  R_MIN  = MIN_WIDTH'(RESET_MIN);

   state_t                w_state;
   logic                  w_tick;
   logic                  w_pre_clr;
   hour_pm_t              w_hour_inc;
   logic [MIN_WIDTH-1:0]  r_sec;
   logic [MIN_WIDTH-1:0]  r_min;
   logic [HOUR_WIDTH-1:0] r_hour;
   logic                  r_pm;
   logic                  r_sec_pulse;

   // mode decode: set beats run, run beats stopped; it governs this edge
   always_comb begin
      w_state = ST_STOPPED;
      if (bus.set_mode_pi)
         w_state = ST_SET;
      else if (bus.run_en_pi)
         w_state = ST_RUN;
   end

   // prescaler restarts from zero whenever SET is active or on reset
   assign w_pre_clr  = !rst_n_pi || (w_state == ST_SET);
   assign w_hour_inc = next_hour(r_hour, r_pm);

   tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_pre (
      .clk    (clk_pi),
      .i_clr  (w_pre_clr),
      .i_en   (w_state == ST_RUN),
      .o_tick (w_tick)
   );

   // time-of-day registers: carry chain in RUN, user stepping in SET
   always_ff @(posedge clk_pi) begin
      if (!rst_n_pi) begin
         r_sec       <= '0;
         r_min       <= R_MIN;
         r_hour      <= R_HOUR;
         r_pm        <= 1'b0;
         r_sec_pulse <= 1'b0;
      end else begin
         r_sec_pulse <= 1'b0;
         case (w_state)
            ST_RUN: begin
               r_sec_pulse <= w_tick;
               if (w_tick) begin
                  r_sec <= (r_sec == MAX_SEC) ? '0 : r_sec + 6'd1;
                  if (r_sec == MAX_SEC) begin
                     r_min <= next_min(r_min);
                     if (r_min == MAX_MIN) begin
                        r_hour <= w_hour_inc.hour;
                        r_pm   <= w_hour_inc.pm;
                     end
                  end
               end
            end
            ST_SET: begin
               r_sec <= '0;
               // minute and hour steps are independent: no carry between them
               if (bus.increment_minute_pi)
                  r_min <= next_min(r_min);
               if (bus.increment_hour_pi) begin
                  r_hour <= w_hour_inc.hour;
                  r_pm   <= w_hour_inc.pm;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.seconds_po   = r_sec;
   assign bus.minutes_po   = r_min;
   assign bus.hours_po     = r_hour;
   assign bus.pm_po        = r_pm;
   assign bus.sec_pulse_po = r_sec_pulse;

`ifdef TIMEKEEPER_CHIME_EN
   logic r_chime;

   // chime only on a counted rollover into a new hour, never on SET stepping
   always_ff @(posedge clk_pi) begin
      if (!rst_n_pi)
         r_chime <= 1'b0;
      else
         r_chime <= (w_state == ST_RUN) && w_tick &&
                    (r_sec == MAX_SEC) && (r_min == MAX_MIN);
   end

   assign bus.chime_po = r_chime;
`endif
endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper with TICKS_PER_SEC = 4.
module tb_clock_timekeeper;
   import clock_pkg::*;

   localparam int TPS = 4;

   logic        clk_pi   = 1'b0;
   logic        rst_n_pi = 1'b0;
   int          errors   = 0;
   int          checks   = 0;
   logic        set_bad;
   logic [11:0] pulse_map;

   always #5 clk_pi = ~clk_pi;

   clock_timekeeper_if tk_if ();

   clock_timekeeper #(
      .TICKS_PER_SEC (TPS),
      .RESET_HOUR    (12),
      .RESET_MIN     (0)
   ) dut (
      .clk_pi   (clk_pi),
      .rst_n_pi (rst_n_pi),
      .bus      (tk_if.slave)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_pi);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s, input int pm);
      chk({tag, ".hour"}, 32'(tk_if.hours_po), h);
      chk({tag, ".min"},  32'(tk_if.minutes_po), m);
      chk({tag, ".sec"},  32'(tk_if.seconds_po), s);
      chk({tag, ".pm"},   32'(tk_if.pm_po), pm);
   endtask

   // step hours/minutes in SET; flags any nonzero seconds or sec pulse seen
   task automatic set_steps(input int nh, input int nm);
      int n;
      n = (nh > nm) ? nh : nm;
      set_bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         tk_if.increment_hour_pi   = (i < nh);
         tk_if.increment_minute_pi = (i < nm);
         step(1);
         if (tk_if.seconds_po !== 6'd0 || tk_if.sec_pulse_po !== 1'b0)
            set_bad = 1'b1;
      end
      tk_if.increment_hour_pi   = 1'b0;
      tk_if.increment_minute_pi = 1'b0;
   endtask

   initial begin
      tk_if.run_en_pi           = 1'b0;
      tk_if.set_mode_pi         = 1'b0;
      tk_if.increment_minute_pi = 1'b0;
      tk_if.increment_hour_pi   = 1'b0;

      // reset state
      step(2);
      chk_time("reset", 12, 0, 0, 0);
      chk("reset.pulse", 32'(tk_if.sec_pulse_po), 0);

      // free run: pulses after edges 4, 8, 12
      rst_n_pi        = 1'b1;
      tk_if.run_en_pi = 1'b1;
      pulse_map       = '0;
      for (int k = 0; k < 12; k++) begin
         step(1);
         pulse_map[k] = tk_if.sec_pulse_po;
      end
      chk("run.pulse_map", 32'(pulse_map), 32'h888);
      chk_time("run12", 12, 0, 3, 0);

      // SET from 12:00 AM to 11:59 AM
      tk_if.run_en_pi   = 1'b0;
      tk_if.set_mode_pi = 1'b1;
      set_steps(11, 59);
      chk_time("set1159", 11, 59, 0, 0);
      chk("set1159.quiet", 32'(set_bad), 0);

      // leave SET: first tick exactly TPS cycles later
      tk_if.set_mode_pi = 1'b0;
      tk_if.run_en_pi   = 1'b1;
      step(3);
      chk("exit_set.early_sec", 32'(tk_if.seconds_po), 0);
      chk("exit_set.early_pulse", 32'(tk_if.sec_pulse_po), 0);
      step(1);
      chk("exit_set.first_sec", 32'(tk_if.seconds_po), 1);
      chk("exit_set.first_pulse", 32'(tk_if.sec_pulse_po), 1);
      step(228);
      chk_time("t115958", 11, 59, 58, 0);
      step(4);
      chk_time("t115959", 11, 59, 59, 0);
`ifdef TIMEKEEPER_CHIME_EN
      chk("t115959.chime", 32'(tk_if.chime_po), 0);
`endif
      step(4);
      chk_time("noon", 12, 0, 0, 1);
      chk("noon.pulse", 32'(tk_if.sec_pulse_po), 1);
`ifdef TIMEKEEPER_CHIME_EN
      chk("noon.chime", 32'(tk_if.chime_po), 1);
`endif

      // 12:59:59 PM -> 1:00:00 PM
      tk_if.run_en_pi   = 1'b0;
      tk_if.set_mode_pi = 1'b1;
      set_steps(0, 59);
      chk_time("set1259", 12, 59, 0, 1);
`ifdef TIMEKEEPER_CHIME_EN
      chk("set1259.chime", 32'(tk_if.chime_po), 0);
`endif
      tk_if.set_mode_pi = 1'b0;
      tk_if.run_en_pi   = 1'b1;
      step(236);
      chk_time("t125959", 12, 59, 59, 1);
      step(4);
      chk_time("t0100", 1, 0, 0, 1);
`ifdef TIMEKEEPER_CHIME_EN
      chk("t0100.chime", 32'(tk_if.chime_po), 1);
`endif

      // SET with run_en still high; reach 11:59 AM then step both at once
      tk_if.set_mode_pi = 1'b1;
      set_steps(22, 59);
      chk_time("set_run1159", 11, 59, 0, 0);
      chk("set_run1159.quiet", 32'(set_bad), 0);
      tk_if.increment_hour_pi   = 1'b1;
      tk_if.increment_minute_pi = 1'b1;
      step(1);
      tk_if.increment_hour_pi   = 1'b0;
      tk_if.increment_minute_pi = 1'b0;
      chk_time("both_inc", 12, 0, 0, 1);
      chk("both_inc.pulse", 32'(tk_if.sec_pulse_po), 0);
`ifdef TIMEKEEPER_CHIME_EN
      chk("both_inc.chime", 32'(tk_if.chime_po), 0);
`endif
      step(6);
      chk("set_hold.sec", 32'(tk_if.seconds_po), 0);
      chk("set_hold.pulse", 32'(tk_if.sec_pulse_po), 0);

      // increments ignored in RUN and STOPPED; prescaler holds in STOPPED
      tk_if.set_mode_pi         = 1'b0;
      tk_if.increment_hour_pi   = 1'b1;
      tk_if.increment_minute_pi = 1'b1;
      step(2);
      chk("run_ign.hour", 32'(tk_if.hours_po), 12);
      chk("run_ign.min", 32'(tk_if.minutes_po), 0);
      tk_if.run_en_pi = 1'b0;
      step(3);
      tk_if.increment_hour_pi   = 1'b0;
      tk_if.increment_minute_pi = 1'b0;
      chk("stop_ign.hour", 32'(tk_if.hours_po), 12);
      chk("stop_ign.min", 32'(tk_if.minutes_po), 0);
      chk("stop.sec", 32'(tk_if.seconds_po), 0);
      chk("stop.pulse", 32'(tk_if.sec_pulse_po), 0);
      tk_if.run_en_pi = 1'b1;
      step(2);
      chk("resume.sec", 32'(tk_if.seconds_po), 1);
      chk("resume.pulse", 32'(tk_if.sec_pulse_po), 1);

      // reset in the middle of SET at 7:42 PM
      tk_if.run_en_pi   = 1'b0;
      tk_if.set_mode_pi = 1'b1;
      set_steps(7, 42);
      chk_time("set0742", 7, 42, 0, 1);
      rst_n_pi                  = 1'b0;
      tk_if.increment_hour_pi   = 1'b1;
      tk_if.increment_minute_pi = 1'b1;
      step(1);
      rst_n_pi                  = 1'b1;
      tk_if.set_mode_pi         = 1'b0;
      tk_if.increment_hour_pi   = 1'b0;
      tk_if.increment_minute_pi = 1'b0;
      chk_time("rst_set", 12, 0, 0, 0);
      chk("rst_set.pulse", 32'(tk_if.sec_pulse_po), 0);
      step(5);
      chk_time("rst_stopped", 12, 0, 0, 0);
      chk("rst_stopped.pulse", 32'(tk_if.sec_pulse_po), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
